easyaxi_resp_sched: RTL and testbench
=====================================

Name: easyaxi_resp_sched

Overview:
Slave-side read response scheduler. It is the responder counterpart of the master-side per-ID order tracker. It accepts read requests (id, len) into an OST_DEPTH-entry table and, after a fixed service delay, returns each request as an R burst of len+1 beats. Bursts with the same ID are returned strictly in arrival order. Bursts with different IDs may be returned out of order, chosen by round-robin. It is used as the reorder-capable slave model and as the response engine in the EasyAXI slave.

Parameters:
OST_DEPTH, 16, number of outstanding request entries (power of 2, >=2)
ID_WIDTH, 4, request/response ID width
LEN_WIDTH, 8, burst length field width (beats = len+1)
DATA_WIDTH, 32, response data width (must be >= ID_WIDTH+LEN_WIDTH)
RESP_DELAY, 4, cycles an entry waits after acceptance before it becomes eligible (0 allowed)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active high
req_valid  in  1  request valid
req_ready  out  1  request ready
req_id  in  ID_WIDTH  request ID
req_len  in  LEN_WIDTH  burst length minus one
resp_valid  out  1  response beat valid
resp_ready  in  1  response beat ready
resp_id  out  ID_WIDTH  ID of current beat
resp_data  out  DATA_WIDTH  beat data, zero-extended {resp_id, beat_index}
resp_resp  out  2  response code, always 2'b00 (OKAY)
resp_last  out  1  final beat of burst
ost_cnt  out  $clog2(OST_DEPTH)+1  number of occupied entries

Behaviour:
- Reset: all entries invalid; FSM=IDLE; rr_ptr=0; ost_cnt=0; resp_valid=0; resp_last=0; resp_id=0; resp_data=0; resp_resp=0.
- Reset asserted mid-burst aborts the burst. All outputs take their reset values on the next edge, and no further beats are produced.
- Per-entry state: valid, id, len, beat_cnt, delay_cnt, plus an OST_DEPTH x OST_DEPTH age matrix. older[i][j]=1 means entry i arrived before entry j.
- req_ready = (ost_cnt != OST_DEPTH). It depends only on registered state, never on req_valid.
- Acceptance (req_valid & req_ready):
  - Writes the lowest-index free entry: valid=1, id, len, beat_cnt=0, delay_cnt=RESP_DELAY.
  - Marks all currently valid entries as older than the new entry.
- delay_cnt decrements by 1 each cycle while nonzero.
- Entry i is eligible when all of the following hold:
  - valid
  - delay_cnt==0
  - no other valid entry with the same id is older than i
  - i is not currently being served
- FSM IDLE: if any entry is eligible, grant the first eligible index at or after rr_ptr, wrapping round-robin. On that edge: cur=grant, rr_ptr=grant+1 (mod OST_DEPTH), go to BURST. Otherwise stay in IDLE.
- FSM BURST:
  - resp_valid=1; resp_id, resp_data and resp_last reflect entry cur; resp_last=(beat_cnt==len).
  - Payload is registered and held stable while resp_valid & ~resp_ready.
  - On a handshake that is not the last beat: beat_cnt++.
  - On the last-beat handshake: entry cur is freed and the FSM goes to IDLE.
  - Bursts are never interleaved.
- Latency: request accepted in cycle T → first resp_valid in cycle T+RESP_DELAY+2, assuming no other traffic. There is one IDLE bubble cycle between consecutive bursts.
- ost_cnt: +1 on accept, -1 on a last-beat handshake. Both in the same cycle leave it unchanged.
  - A slot freed in cycle T is available to req_ready from cycle T+1.
  - An accept in the same cycle as a free uses a different slot.
- Table full: req_ready=0, and requests are held off without loss.
- Table empty: FSM stays in IDLE with resp_valid=0.
- beat_cnt is LEN_WIDTH wide. len=2^LEN_WIDTH-1 produces exactly 2^LEN_WIDTH beats, with no wrap before last.

Test Plan:
- Single burst: reset, then send id=3, len=2 in cycle 10 with RESP_DELAY=4 and resp_ready=1.
  - Expect beats in cycles 16, 17, 18, with data 0x300, 0x301, 0x302 and last only on the third beat.
  - ost_cnt goes 0→1→0.
- Full table: issue 16 requests of len=0 with resp_ready=0.
  - Expect req_ready=0 after the 16th accept and ost_cnt=16.
  - Release resp_ready; expect req_ready to rise the cycle after the first last-beat handshake.
- Same-ID order: send id=5 len=3, then id=5 len=0.
  - Expect the 4-beat burst to complete fully before the 1-beat burst, even when the second request's delay expires first.
- Cross-ID round-robin: send id=1, id=2, id=1, id=2 (len=0) back-to-back.
  - Expect responses in the order id 1, 2, 1, 2, with each burst separated by one idle cycle.
- Backpressure: during a len=3 burst, toggle resp_ready 1,0,0,1,1,0,1.
  - Expect resp_id, resp_data and resp_last stable while stalled, exactly 4 handshakes, and no beat skipped or duplicated.
- Reset mid-burst: assert rst during beat 2 of a len=7 burst.
  - Expect resp_valid=0, ost_cnt=0 and req_ready=1 the next cycle, with no residual beats afterwards.

Source files
------------

// File: rtl/easyaxi_resp_sched.sv
// Slave-side read response scheduler: per-ID in-order,
// cross-ID round-robin R-burst generation.
module easyaxi_resp_sched #(
  parameter int OST_DEPTH  = 16,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_DELAY = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ID_WIDTH-1:0]           req_id,
  input  logic [LEN_WIDTH-1:0]          req_len,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_WIDTH-1:0]           resp_id,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [1:0]                    resp_resp,
  output logic                          resp_last,
  output logic [$clog2(OST_DEPTH):0]    ost_cnt
);

  localparam int PW = $clog2(OST_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW =
    (RESP_DELAY > 0) ? $clog2(RESP_DELAY + 1) : 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [OST_DEPTH-1:0] vld_q;
  logic [ID_WIDTH-1:0]  id_q    [OST_DEPTH];
  logic [LEN_WIDTH-1:0] len_q   [OST_DEPTH];
  logic [LEN_WIDTH-1:0] beat_q  [OST_DEPTH];
  logic [DW-1:0]        dly_q   [OST_DEPTH];
  logic [OST_DEPTH-1:0] older_q [OST_DEPTH];

  logic [PW-1:0] cur_q;
  logic [PW-1:0] rr_q;
  logic [CW-1:0] cnt_q;

  logic           acc;
  logic           hs;
  logic           fin;
  logic [PW-1:0]  free_idx;
  logic [OST_DEPTH-1:0] blocked;
  logic [OST_DEPTH-1:0] elig;
  logic           gnt_ok;
  logic [PW-1:0]  gnt_idx;
  logic [PW-1:0]  scan_idx;
  logic [LEN_WIDTH-1:0] nxt_beat;

  function automatic logic [DATA_WIDTH-1:0] beat_data(
    input logic [ID_WIDTH-1:0]  id,
    input logic [LEN_WIDTH-1:0] beat
  );
    return DATA_WIDTH'({id, beat});
  endfunction

  assign req_ready = (cnt_q != CW'(OST_DEPTH));
  assign ost_cnt   = cnt_q;
  assign resp_resp = 2'b00;

  assign acc = req_valid & req_ready;
  assign hs  = resp_valid & resp_ready;
  assign fin = hs & resp_last;

  assign nxt_beat = beat_q[cur_q] + LEN_WIDTH'(1);

  // lowest-index free slot for the next request
  always_comb begin
    free_idx = '0;
    for (int i = OST_DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) free_idx = PW'(i);
    end
  end

  // an entry waits for its delay and for older same-ID entries
  always_comb begin
    blocked = '0;
    elig    = '0;
    for (int i = 0; i < OST_DEPTH; i++) begin
      for (int j = 0; j < OST_DEPTH; j++) begin
        if (vld_q[j] && older_q[j][i] &&
            (id_q[j] == id_q[i]))
          blocked[i] = 1'b1;
      end
      elig[i] = vld_q[i] &&
                (dly_q[i] == '0) &&
                !blocked[i] &&
                !((state_q == BURST) &&
                  (cur_q == PW'(i)));
    end
  end

  // round-robin pick starting at rr_q
  always_comb begin
    gnt_ok   = 1'b0;
    gnt_idx  = rr_q;
    scan_idx = rr_q;
    for (int k = 0; k < OST_DEPTH; k++) begin
      scan_idx = rr_q + PW'(k);
      if (!gnt_ok && elig[scan_idx]) begin
        gnt_ok  = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_ok) state_d = BURST;
      BURST:   if (fin)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // entry table: allocate, count down, advance, free
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      for (int i = 0; i < OST_DEPTH; i++) begin
        if (dly_q[i] != '0)
          dly_q[i] <= dly_q[i] - DW'(1);
      end
      if ((state_q == BURST) && hs) begin
        if (resp_last)
          vld_q[cur_q] <= 1'b0;
        else
          beat_q[cur_q] <= nxt_beat;
      end
      if (acc) begin
        vld_q[free_idx]  <= 1'b1;
        id_q[free_idx]   <= req_id;
        len_q[free_idx]  <= req_len;
        beat_q[free_idx] <= '0;
        dly_q[free_idx]  <= DW'(RESP_DELAY);
        older_q[free_idx] <= '0;
        for (int k = 0; k < OST_DEPTH; k++) begin
          older_q[k][free_idx] <= vld_q[k];
        end
      end
    end
  end

  // occupancy counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      unique case ({acc, fin})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // grant bookkeeping and registered beat payload
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q      <= '0;
      rr_q       <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_last  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_ok) begin
            cur_q      <= gnt_idx;
            rr_q       <= gnt_idx + PW'(1);
            resp_valid <= 1'b1;
            resp_id    <= id_q[gnt_idx];
            resp_data  <= beat_data(id_q[gnt_idx], '0);
            resp_last  <= (len_q[gnt_idx] == '0);
          end
        end
        BURST: begin
          if (hs) begin
            if (resp_last) begin
              resp_valid <= 1'b0;
              resp_id    <= '0;
              resp_data  <= '0;
              resp_last  <= 1'b0;
            end else begin
              resp_data <= beat_data(id_q[cur_q], nxt_beat);
              resp_last <= (nxt_beat == len_q[cur_q]);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_easyaxi_resp_sched.sv
// Scoreboard bench for easyaxi_resp_sched: directed
// scenarios plus randomized traffic against a per-ID model.
module tb_easyaxi_resp_sched;

  localparam int OD = 16;
  localparam int IW = 4;
  localparam int LW = 8;
  localparam int DW = 32;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] req_id = '0;
  logic [LW-1:0] req_len = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [IW-1:0] resp_id;
  logic [DW-1:0] resp_data;
  logic [1:0]    resp_resp;
  logic          resp_last;
  logic [4:0]    ost_cnt;

  easyaxi_resp_sched #(
    .OST_DEPTH(OD), .ID_WIDTH(IW), .LEN_WIDTH(LW),
    .DATA_WIDTH(DW), .RESP_DELAY(RD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_len(req_len),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data),
    .resp_resp(resp_resp), .resp_last(resp_last),
    .ost_cnt(ost_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    int id;
    int len;
    int acc;
  } exp_t;

  typedef struct {
    int cyc;
    int id;
    int data;
    int last;
  } beat_t;

  exp_t  sb[$];
  beat_t blog[$];

  int cnt_m = 0;
  bit in_burst = 0;
  int cur_k, cur_id, cur_len, beat_m;
  bit hold_v = 0;
  logic [IW-1:0] h_id;
  logic [DW-1:0] h_data;
  logic          h_last;
  bit fin_m;
  int fk;
  exp_t e;
  beat_t b;

  // monitor: compares every presented beat with the model
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      in_burst = 0;
      hold_v = 0;
      cnt_m = 0;
    end else begin
      fin_m = 0;
      chk("ost_cnt", ost_cnt, cnt_m);
      chk("req_ready", req_ready, (cnt_m != OD));
      if (hold_v) begin
        chk("stall_valid", resp_valid, 1);
        chk("stall_id", resp_id, h_id);
        chk("stall_data", resp_data, h_data);
        chk("stall_last", resp_last, h_last);
      end
      hold_v = resp_valid && !resp_ready;
      h_id = resp_id;
      h_data = resp_data;
      h_last = resp_last;
      if (resp_valid && !in_burst) begin
        fk = -1;
        foreach (sb[k])
          if (fk < 0 && sb[k].id == int'(resp_id)) fk = k;
        if (fk < 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: id %0h data %0h",
                   resp_id, resp_data);
        end else begin
          in_burst = 1;
          cur_k = fk;
          cur_id = sb[fk].id;
          cur_len = sb[fk].len;
          beat_m = 0;
          chk("latency_min",
              (cyc >= sb[fk].acc + RD + 2), 1);
        end
      end
      if (resp_valid && in_burst) begin
        chk("resp_id", resp_id, cur_id);
        chk("resp_data", resp_data,
            (cur_id << LW) | beat_m);
        chk("resp_last", resp_last, (beat_m == cur_len));
        chk("resp_resp", resp_resp, 0);
        if (resp_ready) begin
          b.cyc = cyc;
          b.id = int'(resp_id);
          b.data = int'(resp_data);
          b.last = int'(resp_last);
          blog.push_back(b);
          if (beat_m == cur_len) begin
            sb.delete(cur_k);
            in_burst = 0;
            fin_m = 1;
          end else begin
            beat_m++;
          end
        end
      end
      if (req_valid && req_ready) begin
        e.id = int'(req_id);
        e.len = int'(req_len);
        e.acc = cyc;
        sb.push_back(e);
        cnt_m++;
      end
      if (fin_m) cnt_m--;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", resp_valid, 0);
    chk("rst_last", resp_last, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_cnt", ost_cnt, 0);
    chk("rst_ready", req_ready, 1);
    blog.delete();
  endtask

  task automatic issue(input int id, input int len);
    req_valid = 1'b1;
    req_id = IW'(id);
    req_len = LW'(len);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int max);
    int k = 0;
    while (blog.size() < n && k < max) begin
      @(posedge clk);
      #1 k++;
    end
    chk("beat_count", blog.size(), n);
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while ((sb.size() != 0 || resp_valid) && k < max) begin
      @(posedge clk);
      #1 k++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  int a;
  int k;
  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
  int rr_ids[4] = '{1, 2, 1, 2};

  initial begin
    repeat (3) @(posedge clk);
    do_reset();

    // single burst latency and data
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 a = cyc;
    issue(3, 2);
    chk("single_cnt1", ost_cnt, 1);
    wait_beats(3, 30);
    if (blog.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("single_cyc", blog[i].cyc, a + RD + 2 + i);
        chk("single_data", blog[i].data, 'h300 + i);
        chk("single_last", blog[i].last, (i == 2));
      end
    end
    @(posedge clk);
    #1 chk("single_cnt0", ost_cnt, 0);

    // full table, then release
    do_reset();
    resp_ready = 1'b0;
    for (int i = 0; i < OD; i++) issue(i, 0);
    chk("full_cnt", ost_cnt, OD);
    chk("full_ready", req_ready, 0);
    req_valid = 1'b1;
    req_id = 4'd9;
    req_len = '0;
    repeat (3) @(posedge clk);
    #1 chk("full_hold_ready", req_ready, 0);
    chk("full_stall_valid", resp_valid, 1);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 chk("free_ready", req_ready, 1);
    chk("free_cnt", ost_cnt, OD - 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_idle(200);
    chk("full_beats", blog.size(), OD + 1);

    // same-ID ordering
    do_reset();
    resp_ready = 1'b1;
    issue(5, 3);
    issue(5, 0);
    wait_beats(5, 40);
    if (blog.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        chk("same_data", blog[i].data, 'h500 + i);
        chk("same_last", blog[i].last, (i == 3));
      end
      chk("same_data2", blog[4].data, 'h500);
      chk("same_last2", blog[4].last, 1);
      chk("same_gap", blog[4].cyc - blog[3].cyc, 2);
    end

    // cross-ID round robin
    do_reset();
    resp_ready = 1'b1;
    a = cyc;
    for (int i = 0; i < 4; i++) issue(rr_ids[i], 0);
    wait_beats(4, 40);
    if (blog.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr_id", blog[i].id, rr_ids[i]);
        chk("rr_cyc", blog[i].cyc, a + RD + 2 + 2 * i);
      end
    end

    // backpressure during a 4-beat burst
    do_reset();
    resp_ready = 1'b0;
    issue(6, 3);
    k = 0;
    while (!resp_valid && k < 30) begin
      @(posedge clk);
      #1 k++;
    end
    chk("bp_started", resp_valid, 1);
    for (int i = 0; i < 7; i++) begin
      resp_ready = pat[i][0];
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b0;
    chk("bp_handshakes", blog.size(), 4);
    if (blog.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("bp_data", blog[i].data, 'h600 + i);
        chk("bp_last", blog[i].last, (i == 3));
      end
    end
    chk("bp_valid_after", resp_valid, 0);

    // reset in the middle of a burst
    do_reset();
    resp_ready = 1'b1;
    issue(7, 7);
    k = 0;
    while (blog.size() < 2 && k < 30) begin
      @(posedge clk);
      #1 k++;
    end
    chk("mid_two_beats", blog.size(), 2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_valid", resp_valid, 0);
    chk("mid_cnt", ost_cnt, 0);
    chk("mid_ready", req_ready, 1);
    blog.delete();
    repeat (20) @(posedge clk);
    #1 chk("mid_residual", blog.size(), 0);

    // maximum length burst
    do_reset();
    resp_ready = 1'b1;
    issue(2, 255);
    wait_beats(256, 400);
    if (blog.size() == 256) begin
      chk("max_pre_last", blog[254].last, 0);
      chk("max_last", blog[255].last, 1);
      chk("max_data", blog[255].data, 'h2ff);
    end

    // randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_id = IW'($urandom_range(0, 3));
      req_len = LW'($urandom_range(0, 3));
      resp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    wait_idle(3000);
    chk("rand_cnt", ost_cnt, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
